// File: rtl/lsu_axil_ctrl_if.sv
// AXI4-Lite master bundle used by the MEM-stage load/store controller.
// The master modport is the controller's view; the slave modport is the
// interconnect (or bench memory) view.
interface lsu_axil_ctrl_if #(
  parameter int ADDR_W = 32
);
  // Read address / read data channels
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  // Write address / write data / write response channels
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axil_ctrl.sv
// MEM-stage load/store controller: converts a decoded load/store request into
// a single AXI4-Lite transaction, aligns store data/strobes, extracts and
// extends load data, and holds the pipeline until the transaction retires.
// Only one transaction is ever outstanding.
module lsu_axil_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [2:0] AXPROT = 3'b000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_rd_en_i,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  lsu_axil_ctrl_if.master m_axil
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              isLoad_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awDone_q;
  logic              wDone_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              anyReq;
  logic              misaligned;
  logic              acceptReq;
  logic [31:0]       alignedWdata;
  logic [3:0]        alignedWstrb;
  logic [7:0]        byteLane;
  logic [15:0]       halfLane;
  logic [31:0]       loadValue;

  assign anyReq    = mem_rd_en_i | mem_wr_en_i;
  assign acceptReq = (state_q == IDLE) && anyReq && !misaligned;

  // Address/size legality of the incoming request; size 11 is never legal
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr_i[0];
      2'b10:   misaligned = (mem_addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Replicate store data across lanes and place the byte strobes on the addressed lanes
  always_comb begin
    alignedWdata = mem_wdata_i;
    alignedWstrb = 4'b1111;
    case (mem_size_i)
      2'b00: begin
        alignedWdata = {4{mem_wdata_i[7:0]}};
        alignedWstrb = 4'b0001 << mem_addr_i[1:0];
      end
      2'b01: begin
        alignedWdata = {2{mem_wdata_i[15:0]}};
        alignedWstrb = 4'b0011 << mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the returned word and sign/zero extend it
  always_comb begin
    byteLane  = m_axil.rdata[{addr_q[1:0], 3'b000} +: 8];
    halfLane  = m_axil.rdata[{addr_q[1], 4'b0000} +: 16];
    loadValue = m_axil.rdata;
    case (size_q)
      2'b00:   loadValue = unsigned_q ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
      2'b01:   loadValue = unsigned_q ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
      default: loadValue = m_axil.rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus all handshake, stall and pulse outputs
  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    misaligned_o   = 1'b0;
    rdata_valid_o  = 1'b0;
    bus_err_o      = 1'b0;
    m_axil.arvalid = 1'b0;
    m_axil.rready  = 1'b0;
    m_axil.awvalid = 1'b0;
    m_axil.wvalid  = 1'b0;
    m_axil.bready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          if (misaligned) begin
            misaligned_o = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = mem_rd_en_i ? RD_ADDR : WR_REQ;
          end
        end
      end
      RD_ADDR: begin
        stall_o        = 1'b1;
        m_axil.arvalid = 1'b1;
        if (m_axil.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        stall_o       = 1'b1;
        m_axil.rready = 1'b1;
        if (m_axil.rvalid) state_d = DONE;
      end
      WR_REQ: begin
        stall_o        = 1'b1;
        m_axil.awvalid = !awDone_q;
        m_axil.wvalid  = !wDone_q;
        if ((awDone_q || m_axil.awready) && (wDone_q || m_axil.wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        stall_o       = 1'b1;
        m_axil.bready = 1'b1;
        if (m_axil.bvalid) state_d = DONE;
      end
      DONE: begin
        rdata_valid_o = isLoad_q;
        bus_err_o     = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, per-channel write completion flags, load capture and error tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      isLoad_q   <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      if (acceptReq) begin
        addr_q     <= mem_addr_i[ADDR_W-1:0];
        size_q     <= mem_size_i;
        unsigned_q <= mem_unsigned_i;
        isLoad_q   <= mem_rd_en_i;
        wdata_q    <= alignedWdata;
        wstrb_q    <= alignedWstrb;
        awDone_q   <= 1'b0;
        wDone_q    <= 1'b0;
        err_q      <= 1'b0;
      end
      if (m_axil.awvalid && m_axil.awready) awDone_q <= 1'b1;
      if (m_axil.wvalid && m_axil.wready) wDone_q <= 1'b1;
      if (m_axil.rready && m_axil.rvalid) begin
        rdata_q <= loadValue;
        err_q   <= (m_axil.rresp != 2'b00);
      end
      if (m_axil.bready && m_axil.bvalid) err_q <= (m_axil.bresp != 2'b00);
    end
  end

  assign m_axil.araddr = addr_q;
  assign m_axil.arprot = AXPROT;
  assign m_axil.awaddr = addr_q;
  assign m_axil.awprot = AXPROT;
  assign m_axil.wdata  = wdata_q;
  assign m_axil.wstrb  = wstrb_q;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_lsu_axil_ctrl.sv
// Bench for lsu_axil_ctrl: directed loads/stores against a delay-configurable
// AXI4-Lite memory, a high-level expectation model checked every cycle, and
// hand-computed literal expectations for each transaction.
`timescale 1ns/1ps
module tb_lsu_axil_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdEn, wrEn, uns;
  logic [31:0] addr, wdataIn;
  logic [1:0]  size;
  logic        stall, rdataValid, misaligned, busErr;
  logic [31:0] rdataOut;

  int errors = 0;
  int checks = 0;

  // Memory-side configuration
  int          arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
  int          arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0;
  logic [31:0] cfgRdata = 32'h0;
  logic [1:0]  cfgRresp = 2'b00, cfgBresp = 2'b00;

  // Expectation model state
  logic [31:0] modelAddr = 32'h0, modelWdata = 32'h0, modelRdata = 32'h0;
  logic [3:0]  modelWstrb = 4'h0;
  logic [1:0]  modelSize = 2'b00;
  logic        modelUns = 1'b0;
  logic        checkEn = 1'b0;

  // Observed bus activity
  int          arHsCnt = 0, awHsCnt = 0, wHsCnt = 0, rdValidCnt = 0;
  logic [31:0] lastAraddr = 32'h0, lastAwaddr = 32'h0, lastWdata = 32'h0;
  logic [3:0]  lastWstrb = 4'h0;
  logic        prevArWait = 1'b0, prevAwWait = 1'b0, prevWWait = 1'b0;

  lsu_axil_ctrl_if #(.ADDR_W(32)) axil ();

  lsu_axil_ctrl #(.ADDR_W(32), .AXPROT(3'b000)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_rd_en_i    (rdEn),
    .mem_wr_en_i    (wrEn),
    .mem_addr_i     (addr),
    .mem_wdata_i    (wdataIn),
    .mem_size_i     (size),
    .mem_unsigned_i (uns),
    .stall_o        (stall),
    .rdata_o        (rdataOut),
    .rdata_valid_o  (rdataValid),
    .misaligned_o   (misaligned),
    .bus_err_o      (busErr),
    .m_axil         (axil)
  );

  always #5 clk = ~clk;

  // Load result as the ISA defines it: pick the addressed bytes, then extend
  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    int unsigned bits, shift;
    logic [31:0] mask, raw;
    if (sz == 2'd2) return word;
    bits  = (sz == 2'd0) ? 8 : 16;
    shift = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
    mask  = (32'h1 << bits) - 32'h1;
    raw   = (word >> shift) & mask;
    if (!u && raw[bits-1]) raw = raw | ~mask;
    return raw;
  endfunction

  // Bus image of a store: data copied into every lane, strobes on the addressed bytes
  function automatic void storeImage(input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz,
                                     output logic [31:0] wd, output logic [3:0] st);
    case (sz)
      2'd0: begin wd = (d & 32'hFF) * 32'h01010101;   st = 4'(1 << (a % 4)); end
      2'd1: begin wd = (d & 32'hFFFF) * 32'h00010001; st = 4'(3 << (a % 4)); end
      default: begin wd = d; st = 4'hF; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a request at the falling edge and record what the model expects of it
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, input logic u);
    @(negedge clk);
    rdEn = rd; wrEn = wr; addr = a; wdataIn = d; size = sz; uns = u;
    if (rd || wr) begin
      modelAddr = a; modelSize = sz; modelUns = u;
      storeImage(d, a, sz, modelWdata, modelWstrb);
    end
  endtask

  // Wait for the pipeline to be released and check the retirement cycle
  task automatic runTxn(input string name, input int expStall, input logic expRdValid, input logic expErr,
                        input logic expMis, input logic [31:0] expRdata, input int expArHs, input int expAwHs);
    int stallCycles, arBase, awBase, wBase, rvBase;
    arBase = arHsCnt; awBase = awHsCnt; wBase = wHsCnt; rvBase = rdValidCnt;
    stallCycles = 0;
    #3;
    while (stall === 1'b1 && stallCycles < 60) begin
      stallCycles++;
      @(negedge clk); #3;
    end
    if (stallCycles >= 60) begin
      checks++; errors++;
      $display("[TB] FAIL %s_timeout: stall still high after %0d cycles, expected release", name, stallCycles);
    end
    checkOutput({name, "_stall"},   stallCycles, expStall);
    checkOutput({name, "_rvalid"},  {31'b0, rdataValid}, {31'b0, expRdValid});
    checkOutput({name, "_buserr"},  {31'b0, busErr}, {31'b0, expErr});
    checkOutput({name, "_misalgn"}, {31'b0, misaligned}, {31'b0, expMis});
    checkOutput({name, "_rdata"},   rdataOut, expRdata);
    checkOutput({name, "_arcount"}, arHsCnt - arBase, expArHs);
    checkOutput({name, "_awcount"}, awHsCnt - awBase, expAwHs);
    checkOutput({name, "_wcount"},  wHsCnt - wBase, expAwHs);
    checkOutput({name, "_rvcount"}, rdValidCnt - rvBase, {31'b0, expRdValid});
  endtask

  // One cycle with no request: nothing stalls and every pulse has ended
  task automatic idleCycle(input string name);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #3;
    checkOutput({name, "_idle"}, {28'b0, stall, misaligned, rdataValid, busErr}, 32'h0);
  endtask

  // AXI4-Lite memory with per-channel ready/valid delays, updated mid-cycle
  initial begin
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = 32'h0; axil.rresp = 2'b00;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (axil.arvalid === 1'b1) begin
        if (arCnt >= arDelay) axil.arready = 1'b1; else begin axil.arready = 1'b0; arCnt++; end
      end else begin axil.arready = 1'b0; arCnt = 0; end
      if (axil.rready === 1'b1) begin
        if (rCnt >= rDelay) begin axil.rvalid = 1'b1; axil.rdata = cfgRdata; axil.rresp = cfgRresp; end
        else begin axil.rvalid = 1'b0; axil.rdata = 32'hA5A5A5A5; rCnt++; end
      end else begin axil.rvalid = 1'b0; axil.rdata = 32'hA5A5A5A5; axil.rresp = 2'b00; rCnt = 0; end
      if (axil.awvalid === 1'b1) begin
        if (awCnt >= awDelay) axil.awready = 1'b1; else begin axil.awready = 1'b0; awCnt++; end
      end else begin axil.awready = 1'b0; awCnt = 0; end
      if (axil.wvalid === 1'b1) begin
        if (wCnt >= wDelay) axil.wready = 1'b1; else begin axil.wready = 1'b0; wCnt++; end
      end else begin axil.wready = 1'b0; wCnt = 0; end
      if (axil.bready === 1'b1) begin
        if (bCnt >= bDelay) begin axil.bvalid = 1'b1; axil.bresp = cfgBresp; end
        else begin axil.bvalid = 1'b0; bCnt++; end
      end else begin axil.bvalid = 1'b0; axil.bresp = 2'b00; bCnt = 0; end
    end
  end

  // Every-cycle comparison against the model: held load result, bus payloads, valid stability
  initial begin
    forever begin
      @(negedge clk); #2;
      if (checkEn) begin
        checkOutput("rdata_model", rdataOut, modelRdata);
        if (axil.arvalid === 1'b1) begin
          checkOutput("araddr", axil.araddr, modelAddr);
          checkOutput("arprot", {29'b0, axil.arprot}, 32'h0);
        end
        if (axil.awvalid === 1'b1) begin
          checkOutput("awaddr", axil.awaddr, modelAddr);
          checkOutput("awprot", {29'b0, axil.awprot}, 32'h0);
        end
        if (axil.wvalid === 1'b1) begin
          checkOutput("wdata", axil.wdata, modelWdata);
          checkOutput("wstrb", {28'b0, axil.wstrb}, {28'b0, modelWstrb});
        end
        if (prevArWait) checkOutput("arvalid_held", {31'b0, axil.arvalid}, 32'h1);
        if (prevAwWait) checkOutput("awvalid_held", {31'b0, axil.awvalid}, 32'h1);
        if (prevWWait)  checkOutput("wvalid_held",  {31'b0, axil.wvalid}, 32'h1);
        if (misaligned === 1'b1)
          checkOutput("misalign_quiet", {29'b0, axil.arvalid, axil.awvalid, axil.wvalid}, 32'h0);
        if (axil.arvalid === 1'b1 && axil.arready === 1'b1) begin arHsCnt++; lastAraddr = axil.araddr; end
        if (axil.awvalid === 1'b1 && axil.awready === 1'b1) begin awHsCnt++; lastAwaddr = axil.awaddr; end
        if (axil.wvalid === 1'b1 && axil.wready === 1'b1) begin
          wHsCnt++; lastWdata = axil.wdata; lastWstrb = axil.wstrb;
        end
        if (rdataValid === 1'b1) rdValidCnt++;
      end
      prevArWait = (axil.arvalid === 1'b1) && (axil.arready !== 1'b1) && (rst !== 1'b1);
      prevAwWait = (axil.awvalid === 1'b1) && (axil.awready !== 1'b1) && (rst !== 1'b1);
      prevWWait  = (axil.wvalid === 1'b1) && (axil.wready !== 1'b1) && (rst !== 1'b1);
      if (rst === 1'b1) modelRdata = 32'h0;
      else if (axil.rvalid === 1'b1 && axil.rready === 1'b1)
        modelRdata = loadExtend(axil.rdata, modelAddr, modelSize, modelUns);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence
  initial begin
    rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; addr = 32'h0; wdataIn = 32'h0; size = 2'b00; uns = 1'b0;
    @(negedge clk); @(negedge clk); #3;
    checkOutput("reset_outputs", {28'b0, stall, misaligned, rdataValid, busErr}, 32'h0);
    checkOutput("reset_rdata", rdataOut, 32'h0);
    checkOutput("reset_valids", {27'b0, axil.arvalid, axil.rready, axil.awvalid, axil.wvalid, axil.bready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] LB 0x103 sign-extended byte lane 3");
    cfgRdata = 32'h80000000;
    applyStimulus(1'b1, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
    runTxn("lb", 3, 1'b1, 1'b0, 1'b0, 32'hFFFFFF80, 1, 0);
    checkOutput("lb_araddr", lastAraddr, 32'h103);
    idleCycle("lb");

    $display("[TB] SH 0x202 with awready two cycles after wready");
    awDelay = 2;
    applyStimulus(1'b0, 1'b1, 32'h202, 32'h0000BEEF, 2'b01, 1'b0);
    runTxn("sh", 5, 1'b0, 1'b0, 1'b0, 32'hFFFFFF80, 0, 1);
    checkOutput("sh_wdata", lastWdata, 32'hBEEFBEEF);
    checkOutput("sh_wstrb", {28'b0, lastWstrb}, 32'hC);
    checkOutput("sh_awaddr", lastAwaddr, 32'h202);
    awDelay = 0;

    $display("[TB] misaligned LW, then LHU 0x102");
    applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0);
    runTxn("lw_mis", 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 0, 0);
    idleCycle("lw_mis");
    cfgRdata = 32'h80010000;
    applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1);
    runTxn("lhu", 3, 1'b1, 1'b0, 1'b0, 32'h00008001, 1, 0);

    $display("[TB] SB lane 1, illegal size, misaligned SH, LH and LBU with error");
    applyStimulus(1'b0, 1'b1, 32'h101, 32'h123456A5, 2'b00, 1'b0);
    runTxn("sb", 3, 1'b0, 1'b0, 1'b0, 32'h00008001, 0, 1);
    checkOutput("sb_wdata", lastWdata, 32'hA5A5A5A5);
    checkOutput("sb_wstrb", {28'b0, lastWstrb}, 32'h2);
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
    runTxn("size11", 0, 1'b0, 1'b0, 1'b1, 32'h00008001, 0, 0);
    applyStimulus(1'b0, 1'b1, 32'h203, 32'h1111, 2'b01, 1'b0);
    runTxn("sh_mis", 0, 1'b0, 1'b0, 1'b1, 32'h00008001, 0, 0);
    cfgRdata = 32'h1234F00D;
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b0);
    runTxn("lh", 3, 1'b1, 1'b0, 1'b0, 32'hFFFFF00D, 1, 0);
    cfgRdata = 32'h00009A00; cfgRresp = 2'b10;
    applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b1);
    runTxn("lbu_err", 3, 1'b1, 1'b1, 1'b0, 32'h0000009A, 1, 0);
    cfgRresp = 2'b00;
    idleCycle("lbu_err");

    $display("[TB] SW with SLVERR and bvalid delayed 5 cycles");
    bDelay = 5; cfgBresp = 2'b10;
    applyStimulus(1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 2'b10, 1'b0);
    runTxn("sw_err", 8, 1'b0, 1'b1, 1'b0, 32'h0000009A, 0, 1);
    checkOutput("sw_wdata", lastWdata, 32'hCAFEF00D);
    checkOutput("sw_wstrb", {28'b0, lastWstrb}, 32'hF);
    bDelay = 0; cfgBresp = 2'b00;
    idleCycle("sw_err");

    $display("[TB] back-to-back LW with arready low for 3 cycles");
    arDelay = 3; cfgRdata = 32'h11223344;
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    runTxn("lw_a", 6, 1'b1, 1'b0, 1'b0, 32'h11223344, 1, 0);
    cfgRdata = 32'h55667788;
    applyStimulus(1'b1, 1'b0, 32'h404, 32'h0, 2'b10, 1'b0);
    runTxn("lw_b", 6, 1'b1, 1'b0, 1'b0, 32'h55667788, 1, 0);
    arDelay = 0;
    idleCycle("lw_b");

    $display("[TB] reset while waiting for read data");
    rDelay = 20;
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
    #3;
    checkOutput("rst_req_stall", {31'b0, stall}, 32'h1);
    @(negedge clk); #3;
    checkOutput("rst_rdaddr", {31'b0, axil.arvalid}, 32'h1);
    @(negedge clk);
    rst = 1'b1; rdEn = 1'b0;
    #3;
    checkOutput("rst_rddata", {31'b0, axil.rready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #3;
    checkOutput("rst_after", {29'b0, stall, axil.rready, axil.arvalid}, 32'h0);
    checkOutput("rst_rdata", rdataOut, 32'h0);
    rDelay = 0; cfgRdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, 32'h504, 32'h0, 2'b10, 1'b0);
    runTxn("lw_post", 3, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1, 0);
    idleCycle("lw_post");

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
